// File: rtl/isp_ol_walker.sv
// isp_ol_walker: Object List walker / sequencer for the ISP polygon parser.
// Fetches OL words for one tile, decodes strips, triangle/quad arrays and
// links, and hands each polygon (address + OL word) to the parser, waiting
// for poly_drawn before issuing the next one.
module isp_ol_walker #(
  parameter int MAX_ENTRIES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] ol_base,
  input  logic [23:0] param_base,
  output logic        ol_rd,
  output logic [23:0] ol_addr,
  input  logic        ol_ack,
  input  logic [31:0] ol_din,
  output logic        render_poly,
  output logic [23:0] poly_addr,
  output logic [31:0] opb_word,
  input  logic        poly_drawn,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(MAX_ENTRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_LINK,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [23:0] r_param_base;
  logic [CW-1:0] r_count;
  logic [4:0]  r_prims;
  logic [4:0]  r_idx;
  logic [8:0]  r_stride_bytes;

  logic        w_shadow;
  logic [2:0]  w_skip;
  logic [2:0]  w_hdr;
  logic [4:0]  w_vtx;
  logic [6:0]  w_stride_words;
  logic [23:0] w_poly_base;
  logic [4:0]  w_arr_prims;
  logic [4:0]  w_idx_next;
  logic        w_more;

  assign busy = (r_state != S_IDLE);

  // Decode polygon geometry from the current OL word and the array position.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_shadow       = opb_word[24];
    w_skip         = opb_word[23:21];
    w_hdr          = w_shadow ? 3'd5 : 3'd3;
    w_vtx          = 5'd3 + (w_shadow ? {1'b0, w_skip, 1'b0} : {2'b00, w_skip});
    w_stride_words = 7'(w_hdr);
    if (opb_word[29]) w_stride_words = w_stride_words + 7'(w_vtx) * 7'd4;
    else              w_stride_words = w_stride_words + 7'(w_vtx) * 7'd3;
    w_poly_base    = r_param_base + {1'b0, opb_word[20:0], 2'b00};
    w_arr_prims    = {1'b0, opb_word[28:25]} + 5'd1;
    w_idx_next     = r_idx + 5'd1;
    w_more         = (w_idx_next < r_prims);
  end

  // Walker FSM with registered outputs; abort overrides every transition.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_param_base   <= '0;
      r_count        <= '0;
      r_prims        <= '0;
      r_idx          <= '0;
      r_stride_bytes <= '0;
      ol_rd          <= 1'b0;
      ol_addr        <= '0;
      render_poly    <= 1'b0;
      poly_addr      <= '0;
      opb_word       <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      render_poly <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        ol_rd   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_param_base <= param_base;
              ol_addr      <= {ol_base[23:2], 2'b00};
              error        <= 1'b0;
              r_count      <= '0;
              ol_rd        <= 1'b1;
              r_state      <= S_FETCH;
            end
          end

          S_FETCH: begin
            if (ol_ack) begin
              opb_word <= ol_din;
              ol_rd    <= 1'b0;
              // Saturate so a long chain of links can never wrap the guard.
              if (r_count != CW'(MAX_ENTRIES)) r_count <= r_count + 1'b1;
              r_state  <= S_DECODE;
            end
          end

          S_DECODE: begin
            r_idx          <= '0;
            r_stride_bytes <= {w_stride_words, 2'b00};
            poly_addr      <= w_poly_base;
            if (!opb_word[31]) begin
              // Strip: an empty vertex mask means nothing to draw.
              if (opb_word[30:25] == 6'd0) begin
                r_state <= S_NEXT;
              end else begin
                r_prims     <= 5'd1;
                render_poly <= 1'b1;
                r_state     <= S_ISSUE;
              end
            end else begin
              case (opb_word[31:29])
                3'b100, 3'b101: begin
                  r_prims     <= w_arr_prims;
                  render_poly <= 1'b1;
                  r_state     <= S_ISSUE;
                end
                3'b111: begin
                  if (opb_word[28]) begin
                    done    <= 1'b1;
                    r_state <= S_DONE;
                  end else begin
                    r_state <= S_LINK;
                  end
                end
                default: begin
                  error   <= 1'b1;
                  done    <= 1'b1;
                  r_state <= S_DONE;
                end
              endcase
            end
          end

          // A poly_drawn seen in the issue cycle itself counts as completion.
          S_ISSUE, S_WAIT: begin
            if (poly_drawn) begin
              if (w_more) begin
                r_idx       <= w_idx_next;
                poly_addr   <= poly_addr + 24'(r_stride_bytes);
                render_poly <= 1'b1;
                r_state     <= S_ISSUE;
              end else begin
                r_state <= S_NEXT;
              end
            end else begin
              r_state <= S_WAIT;
            end
          end

          S_NEXT: begin
            if (r_count == CW'(MAX_ENTRIES)) begin
              error   <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              ol_addr <= ol_addr + 24'd4;
              ol_rd   <= 1'b1;
              r_state <= S_FETCH;
            end
          end

          S_LINK: begin
            ol_addr <= {opb_word[23:2], 2'b00};
            ol_rd   <= 1'b1;
            r_state <= S_FETCH;
          end

          S_DONE: begin
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
